// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared definitions for the iterative multiply/divide unit.
//   op_e     : operation encodings as presented on the op input
//   state_e  : control FSM states
//   ITER     : iteration cycles per operation (one result bit per cycle)
//   DIV0_QUOT: quotient returned for a zero divisor
package muldiv_pkg;

   localparam int          ITER      = 32;
   localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if -- request/result bundle between the core and muldiv_unit.
//   master (core side): drives start, op, abort, rs_data, rt_data;
//                       observes busy, done, hi_we, lo_we, hi_out, lo_out.
//   slave  (unit side): the mirror image.
interface muldiv_if;
   import muldiv_pkg::*;

   logic        start;
   op_e         op;
   logic        abort;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        busy;
   logic        done;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   modport master (
      output start, op, abort, rs_data, rt_data,
      input  busy, done, hi_we, lo_we, hi_out, lo_out
   );

   modport slave (
      input  start, op, abort, rs_data, rt_data,
      output busy, done, hi_we, lo_we, hi_out, lo_out
   );

endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative 32-bit MULT/MULTU/DIV/DIVU for the MIPS core.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_if.slave -- start/op/abort/rs_data/rt_data in,
//           busy/done/hi_we/lo_we/hi_out/lo_out out
// An operation keeps busy high for ITER+2 cycles after the start edge:
// ITER iteration cycles, one sign-fix cycle and one write-strobe cycle.
// Iteration works on operand magnitudes; signs are restored in FIX.
module muldiv_unit #(
   parameter int ITER = muldiv_pkg::ITER
) (
   input  logic     clk,
   input  logic     rst_n,
   muldiv_if.slave  bus
);
   import muldiv_pkg::*;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q,   cnt_d;
   op_e         op_q,    op_d;
   logic [63:0] acc_q,   acc_d;    // product, or {remainder, quotient}
   logic [31:0] opnd_q,  opnd_d;   // multiplicand or divisor magnitude
   logic        neg_a_q, neg_a_d;  // rs was negative (signed ops only)
   logic        neg_b_q, neg_b_d;  // rt was negative (signed ops only)
   logic [31:0] hi_q,    hi_d;
   logic [31:0] lo_q,    lo_d;

   // Shared negator: two 32-bit halves, optionally carry-chained into a
   // single 64-bit negation (product fix-up); unchained it negates the two
   // words independently (operand capture, quotient/remainder fix-up).
   logic [31:0] neg_in_hi, neg_in_lo, neg_hi_out, neg_lo_out;
   logic        neg_chain;
   logic [32:0] neg_lo_sum;

   always_comb begin
      neg_in_hi = bus.rs_data;
      neg_in_lo = bus.rt_data;
      neg_chain = 1'b0;
      if (state_q != IDLE) begin
         neg_in_hi = acc_q[63:32];
         neg_in_lo = acc_q[31:0];
         neg_chain = ~op_q[1];
      end
      neg_lo_sum = {1'b0, ~neg_in_lo} + 33'd1;
      neg_lo_out = neg_lo_sum[31:0];
      neg_hi_out = ~neg_in_hi + {31'd0, (neg_chain ? neg_lo_sum[32] : 1'b1)};
   end

   // 33-bit adder/subtractor: add multiplicand to the upper product word, or
   // trial-subtract the divisor from the partial remainder shifted left by one.
   logic [32:0] add_a, add_res;

   always_comb begin
      add_a   = op_q[1] ? {acc_q[63:32], acc_q[31]} : {1'b0, acc_q[63:32]};
      add_res = op_q[1] ? (add_a - {1'b0, opnd_q}) : (add_a + {1'b0, opnd_q});
   end

   logic        cap_signed, cap_neg_a, cap_neg_b;
   logic [31:0] abs_rs, abs_rt;

   always_comb begin
      cap_signed = ~bus.op[0];
      cap_neg_a  = cap_signed & bus.rs_data[31];
      cap_neg_b  = cap_signed & bus.rt_data[31];
      abs_rs     = cap_neg_a ? neg_hi_out : bus.rs_data;
      abs_rt     = cap_neg_b ? neg_lo_out : bus.rt_data;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      neg_a_d = neg_a_q;
      neg_b_d = neg_b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               op_d    = bus.op;
               neg_a_d = cap_neg_a;
               neg_b_d = cap_neg_b;
               cnt_d   = 6'd0;
               state_d = RUN;
               if (bus.op[1]) begin
                  acc_d  = {32'd0, abs_rs};
                  opnd_d = abs_rt;
               end else begin
                  acc_d  = {32'd0, abs_rt};
                  opnd_d = abs_rs;
               end
            end
         end
         RUN: begin
            if (bus.abort) begin
               state_d = IDLE;
               cnt_d   = 6'd0;
            end else begin
               if (op_q[1]) begin
                  // Restoring divide; a zero divisor always "fits", which
                  // leaves the dividend magnitude in the remainder word.
                  if (!add_res[32]) acc_d = {add_res[31:0], acc_q[30:0], 1'b1};
                  else              acc_d = {acc_q[62:0], 1'b0};
               end else begin
                  if (acc_q[0]) acc_d = {add_res, acc_q[31:1]};
                  else          acc_d = {1'b0, acc_q[63:1]};
               end
               if (cnt_q == 6'(ITER - 1)) begin
                  cnt_d   = 6'd0;
                  state_d = FIX;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
         end
         FIX: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
               if (op_q[1]) begin
                  hi_d = neg_a_q ? neg_hi_out : acc_q[63:32];
                  if (opnd_q == 32'd0)        lo_d = DIV0_QUOT;
                  else if (neg_a_q ^ neg_b_q) lo_d = neg_lo_out;
                  else                        lo_d = acc_q[31:0];
               end else if (neg_a_q ^ neg_b_q) begin
                  hi_d = neg_hi_out;
                  lo_d = neg_lo_out;
               end else begin
                  hi_d = acc_q[63:32];
                  lo_d = acc_q[31:0];
               end
            end
         end
         DONE: state_d = IDLE;   // strobes fire even if abort is raised now
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 6'd0;
         op_q    <= OP_MULT;
         acc_q   <= 64'd0;
         opnd_q  <= 32'd0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         neg_a_q <= neg_a_d;
         neg_b_q <= neg_b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign bus.busy   = (state_q != IDLE);
   assign bus.done   = (state_q == DONE);
   assign bus.hi_we  = (state_q == DONE);
   assign bus.lo_we  = (state_q == DONE);
   assign bus.hi_out = hi_q;
   assign bus.lo_out = lo_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit for the single-cycle MIPS core. It executes MULT, MULTU, DIV and DIVU over a fixed multi-cycle latency. It hands the 64-bit result to the register file's HI/LO write port as a one-cycle write strobe. It sits between the decode/operand stage (rs/rt data) and the HI/LO registers, and its busy output stalls the core on MFHI/MFLO or a new mul/div while an operation is in flight.

## Interface
- ITER, 32: number of iteration cycles (one result bit per cycle).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, asynchronous and active-low.
- start  in  1  request a new operation; sampled only when busy=0.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- abort  in  1  cancel the in-flight operation (pipeline flush).
- rs_data  in  32  multiplicand / dividend; sampled with start.
- rt_data  in  32  multiplier / divisor; sampled with start.
- busy  out  1  operation in flight (stall request).
- done  out  1  one-cycle pulse: result valid this cycle.
- hi_we  out  1  HI write strobe; equals done.
- lo_we  out  1  LO write strobe; equals done.
- hi_out  out  32  upper product word / remainder.
- lo_out  out  32  lower product word / quotient.

## Operation
- States:
  - IDLE: start=1 captures op and operands, then goes to RUN.
  - RUN: ITER cycles of shift-add (multiply) or restoring shift-subtract (divide) on magnitudes, then goes to FIX.
  - FIX: sign correction and special cases, then goes to DONE.
  - DONE: done=hi_we=lo_we=1, then goes to IDLE.
- busy=1 in RUN, FIX and DONE.
- Signed ops (MULT, DIV): take absolute values at capture. In FIX, negate the product if the operand signs differ. Quotient sign = XOR of operand signs. Remainder sign = dividend sign.
- MULT/MULTU: {hi_out,lo_out} = full 64-bit product, exact and with no overflow.
- Divide by zero (either signedness): lo_out=0xFFFFFFFF, hi_out=dividend. Latency is unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: lo_out=0x80000000, hi_out=0.
- hi_out/lo_out hold their last result until the next DONE. They do not change during RUN or FIX.
- start while busy=1 is ignored. There is no queueing.
- abort=1 in any non-IDLE state: state becomes IDLE at the next edge, with no done and no strobes. If abort and DONE coincide, the strobes still fire (the write is already committed). In IDLE, abort has no effect, and it has priority over start in the same cycle.

## Timing
- Reset: state=IDLE, busy=0, done=hi_we=lo_we=0, hi_out=lo_out=0, and all internal accumulators and counters are 0. Reset takes effect immediately, including mid-operation, and no strobe is emitted.
- Cycle sequence: start sampled at edge 0; busy=1 from edge 0; RUN occupies edges 1..32; FIX updates at edge 33; done/hi_we/lo_we are high between edges 33 and 34, and the register file captures at edge 34; busy=0 after edge 34.
- Total: busy high for 34 cycles. Back-to-back: the next start is accepted in the cycle after done falls.
- Latency is data-independent: no early termination for zero or small operands.
- Iteration counter: 6 bits, counting 0..ITER-1, with no wrap beyond ITER.

## Structure
- Shared package muldiv_pkg holds:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the state enum (IDLE, RUN, FIX, DONE);
  - ITER, DIV0_QUOT = 32'hFFFFFFFF.
- Single module; no sub-module. The datapath is:
  - a 64-bit product/remainder register;
  - a 32-bit operand register;
  - a 33-bit subtractor/adder;
  - a negation stage shared between capture and FIX.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after start; busy low one cycle later.
- MULT 0xFFFFFFFD (−3) × 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV −7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, still at 34 cycles.
- Assert start with new operands at cycle 5 of a busy op -> ignored; first result unchanged; no second done.
- abort at cycle 10 -> busy=0 next cycle, no strobes, hi_out/lo_out keep the prior values. A new start then completes normally.
- rst_n low at cycle 20 -> all outputs 0 immediately and no strobe. After release, MULTU 3×4 -> hi=0, lo=12.
